// File: rtl/val2_imm_encoder_pkg.sv
// Shared definitions for the ARM Val2 immediate encoder: FSM encoding and
// the bit positions of the {rotate_imm, immed_8} / 12-bit offset field.
package val2_imm_encoder_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam int unsigned ROT_STEPS = 16;
  localparam logic [3:0]  ROT_LAST  = 4'(ROT_STEPS - 1);

  localparam int unsigned ROT_MSB  = 11;
  localparam int unsigned ROT_LSB  = 8;
  localparam int unsigned IMM8_MSB = 7;
  localparam int unsigned OFFSET_W = 12;

endpackage

// File: rtl/val2_imm_encoder_rot_check.sv
// Tests one rotate_imm candidate: value is encodable at r when ROL(value, 2*r)
// fits in eight bits.
module val2_imm_encoder_rot_check
  import val2_imm_encoder_pkg::*;
(
  input  logic [31:0]       value,
  input  logic [3:0]        r,
  output logic              hit,
  output logic [IMM8_MSB:0] immed_8
);

  logic [4:0]  amt;
  logic [31:0] t;

  always_comb begin
    amt = {r, 1'b0};
    // A right shift by 32 (amt == 0) yields zero, which leaves t == value.
    t   = (value << amt) | (value >> (6'd32 - {1'b0, amt}));
    hit     = (t[31:IMM8_MSB+1] == '0);
    immed_8 = t[IMM8_MSB:0];
  end

endmodule

// File: rtl/val2_imm_encoder.sv
// Iterative ARM data-processing immediate encoder; also checks the 12-bit
// signed offset range for ldr/str. One rotation is tried per cycle.
module val2_imm_encoder
  import val2_imm_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         value,
  input  logic                is_ldr_or_str,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [OFFSET_W-1:0] Shift_operand
);

  state_e              state_q, state_d;
  logic [3:0]          r_q, r_d;
  logic [31:0]         value_q, value_d;
  logic                mode_q, mode_d;
  logic                found_q, found_d;
  logic [OFFSET_W-1:0] shift_q, shift_d;

  logic                rot_hit;
  logic [IMM8_MSB:0]   rot_imm;
  logic                ldr_fit;
  logic                accept;

  val2_imm_encoder_rot_check u_rot_check (
    .value   (value_q),
    .r       (r_q),
    .hit     (rot_hit),
    .immed_8 (rot_imm)
  );

  // Upper bits all equal to the offset sign bit means it fits signed 12 bits.
  assign ldr_fit = (value_q[31:OFFSET_W-1] == '0) || (value_q[31:OFFSET_W-1] == '1);
  assign accept  = start && (state_q != StSearch);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    value_d = value_q;
    mode_d  = mode_q;
    found_d = found_q;
    shift_d = shift_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StSearch;
          value_d = value;
          mode_d  = is_ldr_or_str;
          r_d     = '0;
          found_d = 1'b0;
          shift_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StSearch: begin
        if (mode_q) begin
          found_d = ldr_fit;
          shift_d = ldr_fit ? value_q[OFFSET_W-1:0] : '0;
          state_d = StDone;
        end else if (rot_hit) begin
          found_d                   = 1'b1;
          shift_d[ROT_MSB:ROT_LSB]  = r_q;
          shift_d[IMM8_MSB:0]       = rot_imm;
          state_d                   = StDone;
        end else if (r_q == ROT_LAST) begin
          found_d = 1'b0;
          shift_d = '0;
          state_d = StDone;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      value_q <= '0;
      mode_q  <= 1'b0;
      found_q <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      value_q <= value_d;
      mode_q  <= mode_d;
      found_q <= found_d;
      shift_q <= shift_d;
    end
  end

  assign busy          = (state_q == StSearch);
  assign done          = (state_q == StDone);
  assign found         = found_q;
  assign Shift_operand = shift_q;

endmodule

// File: tb/tb_val2_imm_encoder.sv
// Directed and model-driven bench for val2_imm_encoder with an expectation
// queue popped whenever done is seen.
module tb_val2_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        is_ldr_or_str;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] Shift_operand;

  always #5 clk = ~clk;

  val2_imm_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .is_ldr_or_str (is_ldr_or_str),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .Shift_operand (Shift_operand)
  );

  typedef struct packed {
    logic        f;
    logic [11:0] s;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  // Brute-force reference: smallest rotation, any immed_8 that reproduces v.
  function automatic void model(input logic [31:0] v, input bit ldr, output logic f,
                                output logic [11:0] s, output int lat);
    f = 1'b0; s = '0; lat = 16;
    if (ldr) begin
      lat = 1;
      if ($signed(v) >= -2048 && $signed(v) <= 2047) begin
        f = 1'b1; s = v[11:0];
      end
      return;
    end
    for (int r = 0; r < 16; r++) begin
      for (int imm = 0; imm < 256; imm++) begin
        if (ror32(32'(imm), 2 * r) == v) begin
          f = 1'b1; s = {4'(r), 8'(imm)}; lat = r + 1;
          return;
        end
      end
    end
  endfunction

  task automatic drive_start(input logic [31:0] v, input logic m, input logic ef,
                             input logic [11:0] es, input int elat, input bit push,
                             input bit in_done);
    exp_t e;
    if (!in_done) @(negedge clk);
    value = v; is_ldr_or_str = m; start = 1'b1;
    if (push) begin
      e.f = ef; e.s = es; e.lat = 32'(elat);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 32'hDEAD_BEEF;
    is_ldr_or_str = ~m;
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int   n = 0;
    int   bcnt = 0;
    bit   seen = 0;
    exp_t e;
    while (n <= 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bcnt++;
      if (poke && n == 3) begin
        start = 1'b1; value = 32'h0000_00FF; is_ldr_or_str = 1'b1;
      end
      if (poke && n == 4) start = 1'b0;
      @(posedge clk);
      n++;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (!seen) return;
    check({tag, " found"}, 32'(found), 32'(e.f));
    check({tag, " shift"}, 32'(Shift_operand), 32'(e.s));
    check({tag, " latency"}, n, e.lat);
    check({tag, " busy_cycles"}, bcnt, e.lat);
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_model(input string tag, input logic [31:0] v, input bit ldr);
    logic        f;
    logic [11:0] s;
    int          lat;
    model(v, ldr, f, s, lat);
    drive_start(v, ldr, f, s, lat, 1, 0);
    wait_done(tag, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; value = '0; is_ldr_or_str = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset found", 32'(found), 32'd0);
    check("reset shift", 32'(Shift_operand), 32'd0);
    rst = 1'b0;

    drive_start(32'h0000_00FF, 1'b0, 1'b1, 12'h0FF, 1, 1, 0);
    wait_done("rot_ff", 0);
    drive_start(32'hFF00_0000, 1'b0, 1'b1, 12'h4FF, 5, 1, 0);
    wait_done("rot_ff000000", 0);
    @(negedge clk);
    check("hold done_low", 32'(done), 32'd0);
    check("hold found", 32'(found), 32'd1);
    check("hold shift", 32'(Shift_operand), 32'h4FF);

    drive_start(32'hF000_000F, 1'b0, 1'b1, 12'h2FF, 3, 1, 0);
    wait_done("rot_f000000f", 0);
    drive_start(32'h0000_0101, 1'b0, 1'b0, 12'h000, 16, 1, 0);
    wait_done("rot_miss_poke", 1);
    drive_start(32'h0000_0000, 1'b0, 1'b1, 12'h000, 1, 1, 0);
    wait_done("rot_zero", 0);

    drive_start(32'hFFFF_F800, 1'b1, 1'b1, 12'h800, 1, 1, 0);
    wait_done("ldr_neg2048", 0);
    drive_start(32'h0000_0800, 1'b1, 1'b0, 12'h000, 1, 1, 0);
    wait_done("ldr_2048", 0);
    drive_start(32'h0000_07FF, 1'b1, 1'b1, 12'h7FF, 1, 1, 0);
    wait_done("ldr_2047", 0);
    drive_start(32'hFFFF_F7FF, 1'b1, 1'b0, 12'h000, 1, 1, 0);
    wait_done("ldr_neg2049", 0);

    // Second start issued while done is high.
    drive_start(32'h3FC0_0000, 1'b0, 1'b1, 12'h5FF, 6, 1, 0);
    wait_done("b2b_first", 0);
    drive_start(32'h0000_0000, 1'b0, 1'b1, 12'h000, 1, 1, 1);
    wait_done("b2b_second", 0);

    for (int i = 0; i < 6; i++) begin
      int          r;
      logic [31:0] imm;
      r   = $urandom_range(0, 15);
      imm = 32'($urandom_range(1, 255));
      run_model($sformatf("rand_enc%0d", i), ror32(imm, 2 * r), 1'b0);
    end
    for (int i = 0; i < 3; i++) run_model($sformatf("rand_raw%0d", i), $urandom, 1'b0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = 32'($signed(12'($urandom_range(0, 4095)))) + 32'($urandom_range(0, 2));
      run_model($sformatf("rand_ldr%0d", i), v, 1'b1);
    end

    // Abort a miss search at r=7.
    drive_start(32'h0000_0101, 1'b0, 1'b0, 12'h000, 16, 0, 0);
    repeat (7) @(posedge clk);
    #2;
    check("abort busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort found", 32'(found), 32'd0);
    check("abort shift", 32'(Shift_operand), 32'd0);
    repeat (2) @(negedge clk);
    check("abort done_held", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort idle_busy", 32'(busy), 32'd0);
    check("abort idle_done", 32'(done), 32'd0);
    drive_start(32'hF000_000F, 1'b0, 1'b1, 12'h2FF, 3, 1, 0);
    wait_done("after_abort", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/val2_imm_encoder.md
Name: val2_imm_encoder

Overview:
- Inverse of the Val2 immediate path: takes a 32-bit constant and searches for the ARM data-processing immediate encoding {rotate_imm[3:0], immed_8[7:0]}.
- The encoding satisfies Val2 = ROR(zero_ext(immed_8), 2*rotate_imm).
- In ldr/str mode it checks whether the value fits the 12-bit sign-extended offset field.
- Sits in the instruction-build/loader path that generates ARM instruction words for the core; iterative, one rotation tested per cycle.

Parameters:
- ROT_STEPS, 16, number of rotate_imm candidates tried (fixed by the ISA, 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only when busy=0 or done=1.
- value  input  32  constant to encode; latched on an accepted start.
- is_ldr_or_str  input  1  latched with start; 1 selects the 12-bit offset check instead of the rotate search.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a result is valid.
- found  output  1  encoding exists; held until the next accepted start.
- Shift_operand  output  12  {rotate_imm, immed_8}, or the raw offset in ldr/str mode; 0 when found=0; held until the next accepted start.

Behaviour:
- Reset: busy=0, done=0, found=0, Shift_operand=0, FSM in IDLE, rotation counter r=0, latched value cleared. Reset mid-search aborts with no done pulse.
- FSM states: IDLE, SEARCH, DONE.
- IDLE --start--> SEARCH, with value and mode latched and r=0.
- Ldr/str mode, single test cycle in SEARCH:
  - Hit if value[31:11] is all 0s or all 1s (fits signed 12-bit).
  - Shift_operand = value[11:0]; else found=0.
  - Go to DONE.
- Rotate mode, each SEARCH cycle:
  - Compute t = ROL(value, 2*r).
  - If t[31:8]==0: hit with rotate_imm=r, immed_8=t[7:0]; go to DONE.
  - Else if r==ROT_STEPS-1: miss, found=0, Shift_operand=0; go to DONE.
  - Else r=r+1.
- Smallest r wins (canonical encoding). value=0 hits at r=0 with Shift_operand=0x000.
- Latency: start sampled at edge E0; a hit at r=k gives done high in the cycle after edge E0+k+1.
  - Ldr/str mode: done after E0+1.
  - Rotate worst-case miss: done after E0+16.
- busy=1 in SEARCH only; done=1 in DONE only, exactly one cycle.
- DONE --start--> SEARCH (back-to-back accepted, so done and a new busy do not overlap). DONE --no start--> IDLE.
- start during SEARCH is ignored; value and is_ldr_or_str are don't-care outside the accepting cycle.
- Counter r is 4 bits; no wrap is possible because termination occurs at r=15.
- Rotate uses 5-bit amount 2*r (0..30); no 32-bit shift case arises.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/SEARCH/DONE, 2 bits).
  - ROT_STEPS.
  - Field slice constants: ROT_MSB=11, ROT_LSB=8, IMM8_MSB=7, OFFSET_W=12.
- One combinational sub-module, val2_rot_check:
  - Inputs: value, r.
  - Outputs: hit, immed_8.
  - Also reusable by a future single-cycle parallel encoder.

Test Plan:
- Rotate mode, value=0x000000FF, start at E0 -> done after E0+1, found=1, Shift_operand=0x0FF; busy high exactly 1 cycle.
- Rotate mode, value=0xFF000000 -> done after E0+5, found=1, Shift_operand=0x4FF. Value=0xF000000F -> done after E0+3, Shift_operand=0x2FF.
- Rotate mode, value=0x00000101 -> busy 16 cycles, done after E0+16, found=0, Shift_operand=0x000.
- Ldr/str mode, value=0xFFFFF800 -> done after E0+1, found=1, Shift_operand=0x800. Value=0x00000800 -> found=0.
- Back-to-back: start 0x3FC00000 (expect 0x5FF after E0+6), new start asserted in the done cycle with 0x00000000 -> done one cycle later with 0x000.
- start pulses during SEARCH are ignored. rst asserted mid-search (r=7) -> outputs zero immediately, no done; the next start behaves normally.
